// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_stage_pkg;

    localparam int INSTR_W = 19;
    localparam logic [INSTR_W-1:0] NOP = 19'b0;

    // Instruction field positions
    localparam int OPCODE_HI = 18;
    localparam int OPCODE_LO = 14;
    localparam int DST_HI    = 13;
    localparam int DST_LO    = 11;
    localparam int SRCA_HI   = 10;
    localparam int SRCA_LO   = 8;
    localparam int SRCB_HI   = 7;
    localparam int SRCB_LO   = 5;

    // Opcode class codes
    localparam logic [2:0] CLASS_JUMP   = 3'b111;
    localparam logic [2:0] CLASS_BRANCH = 3'b101;
    localparam logic [4:0] OP_LOAD      = 5'b10000;
    localparam logic [4:0] OP_STORE     = 5'b10001;

    // RUN: skid empty, HOLD: skid holds the instruction fetched before a stall
    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_skid.sv
// rtl/fetch_stage_skid.sv - one-entry {instruction, pc} skid register
// Ports: clk/rst (async active-high), load captures instr_in/pc_in and sets full,
// clear empties the entry (load wins if both), instr/pc/full report the entry.
module fetch_skid_buffer #(
    parameter int PC_W    = 12,
    parameter int INSTR_W = 19
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc_in,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc,
    output logic               full
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               full_q, full_d;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        full_d  = full_q;
        if (load) begin
            instr_d = instr_in;
            pc_d    = pc_in;
            full_d  = 1'b1;
        end else if (clear) begin
            full_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= '0;
            pc_q    <= '0;
            full_q  <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            full_q  <= full_d;
        end
    end

    assign instr = instr_q;
    assign pc    = pc_q;
    assign full  = full_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, 1-cycle imem fetch, skid buffer and IF/ID pipeline register
// Ports: clk, reset (async active-high); pc_writebar/IF_ID_loadbar stall requests,
// IF_ID_flush bubble request, redirect_valid/redirect_target from branch resolution;
// imem_addr/imem_rdata to synchronous instruction memory; IF_ID_* register outputs.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int PC_W     = 12,
    parameter int INSTR_W  = 19,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pc_writebar,
    input  logic               IF_ID_loadbar,
    input  logic               IF_ID_flush,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_target,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] IF_ID_instruction,
    output logic [PC_W-1:0]    IF_ID_pc,
    output logic [PC_W-1:0]    IF_ID_pc_plus1,
    output logic               IF_ID_valid
);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic               fetch_valid_q, fetch_valid_d;
    logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
    logic [PC_W-1:0]    if_id_pc_q, if_id_pc_d;
    logic [PC_W-1:0]    if_id_pc1_q, if_id_pc1_d;
    logic               if_id_valid_q, if_id_valid_d;

    logic               stall;
    logic               skid_load, skid_clear, skid_full;
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0]    skid_pc;

    assign stall = pc_writebar | IF_ID_loadbar;

    fetch_skid_buffer #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_skid (
        .clk      (clk),
        .rst      (reset),
        .load     (skid_load),
        .clear    (skid_clear),
        .instr_in (imem_rdata),
        .pc_in    (fetch_pc_q),
        .instr    (skid_instr),
        .pc       (skid_pc),
        .full     (skid_full)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_pc_d    = fetch_pc_q;
        fetch_valid_d = fetch_valid_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_pc1_d   = if_id_pc1_q;
        if_id_valid_d = if_id_valid_q;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;

        if (redirect_valid) begin
            // Data returning next cycle belongs to the old path: mark it invalid.
            pc_d          = redirect_target;
            fetch_valid_d = 1'b0;
            skid_clear    = 1'b1;
            state_d       = RUN;
            if_id_instr_d = '0;
            if_id_pc_d    = '0;
            if_id_pc1_d   = '0;
            if_id_valid_d = 1'b0;
        end else begin
            fetch_pc_d    = pc_q;
            fetch_valid_d = 1'b1;
            if (!stall) begin
                pc_d = pc_q + 1'b1;
            end

            case (state_q)
                RUN: begin
                    if (!stall) begin
                        if_id_instr_d = fetch_valid_q ? imem_rdata : '0;
                        if_id_pc_d    = fetch_pc_q;
                        if_id_pc1_d   = fetch_pc_q + 1'b1;
                        if_id_valid_d = fetch_valid_q;
                    end else if (fetch_valid_q) begin
                        // Park the returning word; PC is held, so memory keeps
                        // re-reading the next address while we wait.
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end
                end
                HOLD: begin
                    // imem_rdata is a re-read of the held PC and will come back
                    // again next cycle, so it is dropped here.
                    if (!stall) begin
                        if_id_instr_d = skid_instr;
                        if_id_pc_d    = skid_pc;
                        if_id_pc1_d   = skid_pc + 1'b1;
                        if_id_valid_d = 1'b1;
                        skid_clear    = 1'b1;
                        state_d       = RUN;
                    end
                end
                default: state_d = RUN;
            endcase

            if (IF_ID_flush) begin
                if_id_instr_d = '0;
                if_id_pc_d    = '0;
                if_id_pc1_d   = '0;
                if_id_valid_d = 1'b0;
                if (state_q == HOLD) begin
                    skid_clear = 1'b1;
                    state_d    = RUN;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= PC_W'(RESET_PC);
            fetch_pc_q    <= '0;
            fetch_valid_q <= 1'b0;
            if_id_instr_q <= '0;
            if_id_pc_q    <= '0;
            if_id_pc1_q   <= '0;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_valid_q <= fetch_valid_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_pc1_q   <= if_id_pc1_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign imem_addr         = pc_q;
    assign IF_ID_instruction = if_id_instr_q;
    assign IF_ID_pc          = if_id_pc_q;
    assign IF_ID_pc_plus1    = if_id_pc1_q;
    assign IF_ID_valid       = if_id_valid_q;

endmodule
